result_bcd_display: RTL and testbench
=====================================

# result_bcd_display

Downstream stage of the registered calculator: takes the 2N-bit unsigned result word, converts it to packed BCD with a sequential shift-and-add-3 (double-dabble) engine, and drives one active-low seven-segment pattern per decimal digit. It holds the last converted value on the displays between conversions. It uses a ready/valid handshake on the input and a one-cycle done strobe on the output.

## Interface
- `N`, default 4: operand width of the calculator; the input result is 2N bits.
- `DIGITS`, default 3: number of decimal digits. Elaboration `$error` if 10**DIGITS <= 2**(2N).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `result`  in  2N: unsigned value to display; sampled only on handshake.
- `in_valid`  in  1: `result` is valid this cycle.
- `in_ready`  out  1: block is idle and accepts a value.
- `bcd`  out  4*DIGITS: packed BCD. Digit 0 (units) is in bits [3:0].
- `seg`  out  7*DIGITS: per digit {g,f,e,d,c,b,a}, active-low. Digit 0 is in bits [6:0].
- `out_valid`  out  1: one-cycle strobe when `bcd` and `seg` have just been updated.

## Operation
- States:
  - IDLE → SHIFT on `in_valid && in_ready`.
  - SHIFT → DONE after exactly 2N shift cycles.
  - DONE → IDLE unconditionally.
- IDLE:
  - `in_ready` = 1.
  - On accept: load the shift register with `result`, clear the BCD scratch, clear the counter.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3.
  - Then shift {scratch, bin} left by 1; the binary MSB enters scratch bit 0.
  - Counter increments. Counter width is clog2(2N+1).
- DONE:
  - Copy scratch into the `bcd` register.
  - Load `seg` from the decoded digits.
  - Pulse `out_valid` (registered, high for 1 cycle, coincident with the new `bcd`/`seg`).
- Decoder codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any illegal nibble = 1111111.
- `in_valid` while `in_ready`=0 is ignored and not queued. The upstream must hold or re-present the value.
- `bcd` and `seg` are stable except at the DONE edge. The displays never show intermediate scratch values.
- Arithmetic is purely unsigned. Every 2N-bit value is representable given the DIGITS check.

## Timing
- Accept at clock edge k.
- SHIFT edges are k+1 … k+2N.
- DONE edge is k+2N+1: `bcd`, `seg` and `out_valid`=1 become visible after it. `in_ready`=1 again after the same edge.
- Latency from accept edge to `out_valid` is 2N+1 cycles (9 for N=4). Throughput is one value per 2N+2 cycles.
- A new value can be accepted in the cycle `out_valid` is high (back-to-back).
- Reset values (asynchronous, while `reset`=0):
  - state=IDLE, `in_ready`=1, `out_valid`=0, `bcd`=0.
  - `seg` = digit-zero pattern per the Configuration section.
- Reset asserted mid-conversion:
  - Aborts immediately, with no `out_valid`.
  - The displays revert to reset values.
  - After deassertion the block is IDLE on the first edge.

## Configuration
- `BCD_LEADING_BLANK_EN` defined:
  - Leading-zero blanking on `seg`. Every digit above the most-significant non-zero digit drives 1111111.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Reset `seg`: digit 0 = 1000000, all others 1111111.
  - `bcd` is unaffected.
- Not defined:
  - All digits are always decoded, including leading zeros.
  - Reset `seg` = 1000000 on every digit.

## Test plan
- Reset, then `result`=8'd255 with `in_valid` for 1 cycle (N=4) → `out_valid` 9 cycles after the accept edge, `bcd`=12'h255, `seg`={0100100,0010010,0010010}.
- `result`=8'd99 → `bcd`=12'h099.
  - Without the macro: `seg` digit2=1000000.
  - With `BCD_LEADING_BLANK_EN`: digit2=1111111, digits1/0=0010000.
- `result`=0 → `bcd`=0. With the macro, only digit 0 lit (1000000).
- Accept 8'd123, then pulse `in_valid` with 8'd7 at cycle 3 of SHIFT → ignored. Result: single `out_valid`, `bcd`=12'h123.
- Accept 8'd200, assert `reset`=0 at SHIFT cycle 4 → no `out_valid`, `bcd`=0, `in_ready`=1 after release. Then 8'd42 → `bcd`=12'h042.
- Back-to-back: 8'd10, then 8'd250 accepted in the `out_valid` cycle → two `out_valid` strobes 10 cycles apart, `bcd` 12'h010 then 12'h250.

Source files
------------

// File: rtl/result_bcd_display_if.sv
// rtl/result_bcd_display_if.sv - result/handshake/display bundle for result_bcd_display
interface result_bcd_display_if #(
  parameter int N      = 4,
  parameter int DIGITS = 3
);
  logic [2*N-1:0]      result;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg;
  logic                out_valid;

  modport master (
    output result, in_valid,
    input  in_ready, bcd, seg, out_valid
  );

  modport slave (
    input  result, in_valid,
    output in_ready, bcd, seg, out_valid
  );
endinterface

// File: rtl/result_bcd_display.sv
// rtl/result_bcd_display.sv - sequential double-dabble BCD converter with seven-segment drive
// Optional macro BCD_LEADING_BLANK_EN: blank leading zero digits on seg.
module result_bcd_display #(
  parameter int N      = 4,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  result_bcd_display_if.slave    bus
);
  localparam int W  = 2 * N;
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_SHIFT = CW'(W - 1);

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [SW-1:0] SEG_RST = {{(DIGITS-1){7'h7F}}, 7'h40};
`else
  localparam logic [SW-1:0] SEG_RST = {DIGITS{7'h40}};
`endif

  if (10 ** DIGITS <= 2 ** W) begin : g_range_check
    $error("result_bcd_display: DIGITS too small for a %0d-bit result", W);
  end

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [BW-1:0] scratch_q, scratch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          out_valid_q, out_valid_d;

  logic [BW-1:0] adj;
  logic [SW-1:0] seg_dec;
`ifdef BCD_LEADING_BLANK_EN
  logic          lead;
`endif

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  // Decode straight from scratch so seg lands in the same DONE edge as bcd.
  always_comb begin
    seg_dec = '0;
`ifdef BCD_LEADING_BLANK_EN
    lead = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef BCD_LEADING_BLANK_EN
      if (scratch_q[4*i +: 4] != 4'd0)
        lead = 1'b0;
      seg_dec[7*i +: 7] = (lead && i != 0) ? 7'b1111111 : decode(scratch_q[4*i +: 4]);
`else
      seg_dec[7*i +: 7] = decode(scratch_q[4*i +: 4]);
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    seg_d       = seg_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          bin_d     = bus.result;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[BW-2:0], bin_q[W-1]};
        bin_d     = {bin_q[W-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT)
          state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d       = scratch_q;
        seg_d       = seg_dec;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      seg_q       <= SEG_RST;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      seg_q       <= seg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.bcd       = bcd_q;
  assign bus.seg       = seg_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_result_bcd_display.sv
// tb/tb_result_bcd_display.sv - scoreboard bench for result_bcd_display (N=4, DIGITS=3)
module tb_result_bcd_display;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D9 = 7'b0010000;
`ifdef BCD_LEADING_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = D0;
`endif
  localparam logic [20:0] SEG_RST = {LZ, LZ, D0};

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] seg;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   strobes[$];
  logic [11:0] disp_bcd = 12'h000;
  logic [20:0] disp_seg = SEG_RST;

  result_bcd_display_if #(.N(4), .DIGITS(3)) bus ();

  result_bcd_display #(.N(4), .DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      disp_bcd = 12'h000;
      disp_seg = SEG_RST;
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got bcd %0h expected no strobe (cycle %0d)", bus.bcd, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd", 32'(bus.bcd), 32'(e.bcd));
        chk("seg", 32'(bus.seg), 32'(e.seg));
        chk("latency_cycle", cyc, e.due);
        disp_bcd = e.bcd;
        disp_seg = e.seg;
      end
      strobes.push_back(cyc);
    end else begin
      chk("hold_bcd", 32'(bus.bcd), 32'(disp_bcd));
      chk("hold_seg", 32'(bus.seg), 32'(disp_seg));
    end
  end

  task automatic send(input logic [7:0] v, input logic [11:0] eb, input logic [20:0] es, input bit push);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 for value %0d", v);
      return;
    end
    bus.result   = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) q.push_back('{eb, es, cyc + 9});
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.result   = '0;
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'h0);
    chk("rst_seg", 32'(bus.seg), 32'(SEG_RST));
    reset = 1'b1;

    send(8'd255, 12'h255, {D2, D5, D5}, 1'b1);
    send(8'd99,  12'h099, {LZ, D9, D9}, 1'b1);
    send(8'd0,   12'h000, {LZ, LZ, D0}, 1'b1);
    send(8'd123, 12'h123, {D1, D2, D3}, 1'b1);

    // Present a value during the third SHIFT cycle; it must be dropped.
    repeat (2) @(posedge clk);
    #1;
    bus.result   = 8'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    send(8'd200, 12'h000, 21'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_bcd", 32'(bus.bcd), 32'h0);
    chk("abort_seg", 32'(bus.seg), 32'(SEG_RST));
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    send(8'd42,  12'h042, {LZ, D4, D2}, 1'b1);
    send(8'd10,  12'h010, {LZ, D1, D0}, 1'b1);
    send(8'd250, 12'h250, {D2, D5, D0}, 1'b1);

    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("strobe_count", 32'(strobes.size()), 32'd7);
    if (strobes.size() >= 2)
      chk("back_to_back_gap", 32'(strobes[strobes.size()-1] - strobes[strobes.size()-2]), 32'd10);
    else
      chk("back_to_back_strobes", 32'(strobes.size()), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
